// File: rtl/register_port_arbiter_if.sv
// Request/response and register-file bus of the register-file port arbiter.
// slave is the arbiter's view; master is the requester/register-file side.
interface register_port_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = 5
);
   logic                      hold;
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_ready;
   logic [N_REQ-1:0]          req_we;
   logic [N_REQ*ADDR_W-1:0]   req_addr;
   logic [N_REQ*32-1:0]       req_wdata;
   logic [ADDR_W-1:0]         rf_addr;
   logic                      rf_we;
   logic [31:0]               rf_wd;
   logic [31:0]               rf_rd;
   logic [N_REQ-1:0]          rsp_valid;
   logic [31:0]               rsp_rdata;

   modport slave (
      input  hold, req_valid, req_we, req_addr, req_wdata, rf_rd,
      output req_ready, rf_addr, rf_we, rf_wd, rsp_valid, rsp_rdata
   );

   modport master (
      output hold, req_valid, req_we, req_addr, req_wdata, rf_rd,
      input  req_ready, rf_addr, rf_we, rf_wd, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/register_port_arbiter.sv
// Round-robin arbiter sharing one register-file port among N_REQ requesters.
// Stage 1 registers the winning command onto the port; stage 2 returns the response.
module register_port_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   register_port_arbiter_if.slave bus
);
   localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [IdW-1:0]    r_prio;
   logic              r_s1_valid;
   logic [IdW-1:0]    r_s1_id;
   logic [ADDR_W-1:0] r_rf_addr;
   logic              r_rf_we;
   logic [31:0]       r_rf_wd;
   logic [N_REQ-1:0]  r_rsp_valid;
   logic [31:0]       r_rsp_rdata;

   logic              w_found;
   logic [IdW-1:0]    w_win;
   logic              w_accept;
   logic [N_REQ-1:0]  w_ready;

   function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base,
                                               input int unsigned  off);
      int unsigned sum;
      sum = (32'(base) + off) % N_REQ;
      return sum[IdW-1:0];
   endfunction

   // First valid requester at or after the pointer, wrapping around.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!w_found && bus.req_valid[wrap_add(r_prio, k)]) begin
            w_found = 1'b1;
            w_win   = wrap_add(r_prio, k);
         end
      end
   end

   assign w_accept = w_found && !bus.hold && !rst;
   assign w_ready  = w_accept ? (N_REQ'(1) << w_win) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio      <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_id     <= '0;
         r_rf_addr   <= '0;
         r_rf_we     <= 1'b0;
         r_rf_wd     <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_prio     <= wrap_add(w_win, 1);
            r_s1_valid <= 1'b1;
            r_s1_id    <= w_win;
            r_rf_addr  <= bus.req_addr[32'(w_win)*ADDR_W +: ADDR_W];
            r_rf_we    <= bus.req_we[w_win];
            r_rf_wd    <= bus.req_wdata[32'(w_win)*32 +: 32];
         end else begin
            r_s1_valid <= 1'b0;
            r_rf_we    <= 1'b0;
         end
         // rf_rd is sampled before the write edge, so writes return the old value.
         if (r_s1_valid) begin
            r_rsp_valid <= N_REQ'(1) << r_s1_id;
            r_rsp_rdata <= bus.rf_rd;
         end else begin
            r_rsp_valid <= '0;
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rf_addr   = r_rf_addr;
   assign bus.rf_we     = r_rf_we;
   assign bus.rf_wd     = r_rf_wd;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_register_port_arbiter.sv
// Bench for register_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_register_port_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   register_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

   register_port_arbiter #(.N_REQ(N), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [N-1:0]  t_valid = '1;
   logic [N-1:0]  t_we    = '0;
   logic          t_hold  = 1'b0;
   logic [AW-1:0] t_addr [N];
   logic [31:0]   t_wd   [N];

   always_comb begin
      bus.hold      = t_hold;
      bus.req_valid = t_valid;
      bus.req_we    = t_we;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*AW +: AW]  = t_addr[i];
         bus.req_wdata[i*32 +: 32] = t_wd[i];
      end
   end

   function automatic logic [31:0] init_val(input int a);
      if (a == 5) return 32'hDEADBEEF;
      if (a == 7) return 32'h0;
      return 32'(a) * 32'h9E3779B1 + 32'h1234;
   endfunction

   // Register file seen by the DUT: asynchronous read, write on the clock edge.
   logic [31:0] rf_mem [32];
   assign bus.rf_rd = rf_mem[bus.rf_addr];
   initial begin
      for (int a = 0; a < 32; a++) rf_mem[a] = init_val(a);
      forever begin
         @(posedge clk);
         if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wd;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: pointer, one slot per pipeline stage, shadow register file.
   int unsigned  m_prio = 0;
   bit           m_live = 1'b0;
   bit           s1_v   = 1'b0;
   int unsigned  s1_id  = 0;
   logic [31:0]  s1_rdata;
   logic [N-1:0] e_rsp_valid;
   logic [31:0]  e_rsp_rdata;
   logic         e_rf_we;
   logic [AW-1:0] e_rf_addr;
   logic [31:0]  e_rf_wd;
   logic [31:0]  shadow [32];
   logic [N-1:0] m_acc = '0;
   logic [N-1:0] c_ready;
   bit           c_found;
   int unsigned  c_win;

   initial begin
      for (int a = 0; a < 32; a++) shadow[a] = init_val(a);
      forever begin
         @(negedge clk);
         c_ready = '0;
         c_found = 1'b0;
         c_win   = 0;
         if (!rst && !t_hold) begin
            for (int k = 0; k < N; k++) begin
               if (!c_found && t_valid[(m_prio + k) % N]) begin
                  c_found = 1'b1;
                  c_win   = (m_prio + k) % N;
               end
            end
         end
         if (c_found) c_ready[c_win] = 1'b1;
         if (m_live) begin
            check("model_req_ready", bus.req_ready, c_ready);
            check("model_rf_we", bus.rf_we, e_rf_we);
            check("model_rf_addr", bus.rf_addr, e_rf_addr);
            check("model_rf_wd", bus.rf_wd, e_rf_wd);
            check("model_rsp_valid", bus.rsp_valid, e_rsp_valid);
            check("model_rsp_rdata", bus.rsp_rdata, e_rsp_rdata);
         end
         m_acc = c_ready;
         if (rst) begin
            m_live      = 1'b1;
            m_prio      = 0;
            s1_v        = 1'b0;
            s1_id       = 0;
            e_rf_we     = 1'b0;
            e_rf_addr   = '0;
            e_rf_wd     = '0;
            e_rsp_valid = '0;
            e_rsp_rdata = '0;
         end else begin
            e_rsp_valid = '0;
            if (s1_v) begin
               e_rsp_valid[s1_id] = 1'b1;
               e_rsp_rdata        = s1_rdata;
            end
            s1_v    = 1'b0;
            e_rf_we = 1'b0;
            if (c_found) begin
               s1_v      = 1'b1;
               s1_id     = c_win;
               e_rf_we   = t_we[c_win];
               e_rf_addr = t_addr[c_win];
               e_rf_wd   = t_wd[c_win];
               s1_rdata  = shadow[t_addr[c_win]];
               if (t_we[c_win]) shadow[t_addr[c_win]] = t_wd[c_win];
               m_prio    = (c_win + 1) % N;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst     = 1'b1;
      t_valid = '0;
      t_hold  = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   logic [N-1:0] pend = '0;

   initial begin
      for (int i = 0; i < N; i++) begin
         t_addr[i] = '0;
         t_wd[i]   = '0;
      end
      tick();
      tick();
      @(negedge clk);
      check("reset_ready_zero", bus.req_ready, 0);
      check("reset_rf_we", bus.rf_we, 0);
      check("reset_rf_addr", bus.rf_addr, 0);
      check("reset_rsp_valid", bus.rsp_valid, 0);
      check("reset_rsp_rdata", bus.rsp_rdata, 0);

      // Single read by requester 2 of addr 5.
      tick();
      rst       = 1'b0;
      t_valid   = 4'b0100;
      t_we      = '0;
      t_addr[2] = 5;
      @(negedge clk);
      check("single_ready", bus.req_ready, 4'b0100);
      tick();
      t_valid = '0;
      @(negedge clk);
      check("single_rf_addr", bus.rf_addr, 5);
      check("single_rf_we", bus.rf_we, 0);
      @(negedge clk);
      check("single_rsp_valid", bus.rsp_valid, 4'b0100);
      check("single_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);

      // Full contention from reset: strict rotation.
      do_reset();
      for (int i = 0; i < N; i++) t_addr[i] = AW'($urandom_range(31));
      t_valid = '1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k < 8) check("rotate_ready", bus.req_ready, 64'(1) << (k % 4));
         if (k >= 2) check("rotate_rsp", bus.rsp_valid, 64'(1) << ((k - 2) % 4));
         tick();
         if (k == 7) t_valid = '0;
      end

      // Write then read of addr 7 by requester 1.
      t_valid   = 4'b0010;
      t_we      = 4'b0010;
      t_addr[1] = 7;
      t_wd[1]   = 32'h12345678;
      @(negedge clk);
      check("wr_ready", bus.req_ready, 4'b0010);
      tick();
      t_we = '0;
      @(negedge clk);
      check("rd_ready_b2b", bus.req_ready, 4'b0010);
      check("wr_rf_we", bus.rf_we, 1);
      check("wr_rf_addr", bus.rf_addr, 7);
      check("wr_rf_wd", bus.rf_wd, 32'h12345678);
      tick();
      t_valid = '0;
      @(negedge clk);
      check("wr_rsp_valid", bus.rsp_valid, 4'b0010);
      check("wr_rsp_old", bus.rsp_rdata, 0);
      @(negedge clk);
      check("rd_rsp_valid", bus.rsp_valid, 4'b0010);
      check("rd_rsp_new", bus.rsp_rdata, 32'h12345678);
      tick();

      // Pointer retention: after grant to 1, 3 beats 0.
      t_valid = 4'b1001;
      @(negedge clk);
      check("retain_3_first", bus.req_ready, 4'b1000);
      tick();
      t_valid = 4'b0001;
      @(negedge clk);
      check("retain_0_next", bus.req_ready, 4'b0001);
      tick();

      // Hold for three cycles with requests pending.
      t_valid = '1;
      @(negedge clk);
      check("prehold_ready1", bus.req_ready, 4'b0010);
      tick();
      @(negedge clk);
      check("prehold_ready2", bus.req_ready, 4'b0100);
      tick();
      t_hold = 1'b1;
      @(negedge clk);
      check("hold0_ready", bus.req_ready, 0);
      check("hold0_rsp", bus.rsp_valid, 4'b0010);
      tick();
      @(negedge clk);
      check("hold1_ready", bus.req_ready, 0);
      check("hold1_rsp", bus.rsp_valid, 4'b0100);
      tick();
      @(negedge clk);
      check("hold2_ready", bus.req_ready, 0);
      check("hold2_rsp", bus.rsp_valid, 0);
      tick();
      t_hold = 1'b0;
      @(negedge clk);
      check("hold_resume", bus.req_ready, 4'b1000);
      tick();
      t_valid = '0;
      tick();
      tick();

      // Reset one cycle after accepting a write from requester 2.
      t_valid   = 4'b0100;
      t_we      = 4'b0100;
      t_addr[2] = 9;
      t_wd[2]   = 32'hCAFEF00D;
      @(negedge clk);
      check("rstmid_ready", bus.req_ready, 4'b0100);
      tick();
      t_valid = '0;
      rst     = 1'b1;
      @(negedge clk);
      check("rstmid_ready_in_rst", bus.req_ready, 0);
      tick();
      rst     = 1'b0;
      t_valid = '1;
      t_we    = '0;
      @(negedge clk);
      check("rstmid_rsp_valid", bus.rsp_valid, 0);
      check("rstmid_rf_we", bus.rf_we, 0);
      check("rstmid_rf_addr", bus.rf_addr, 0);
      check("rstmid_rf_wd", bus.rf_wd, 0);
      check("rstmid_rsp_rdata", bus.rsp_rdata, 0);
      check("rstmid_prio0", bus.req_ready, 4'b0001);
      tick();
      t_valid = '0;
      tick();
      tick();

      // Random traffic; requesters keep payload stable until accepted.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (m_acc[i]) pend[i] = 1'b0;
            if (pend[i]) begin
               if ($urandom_range(15) == 0) pend[i] = 1'b0;
            end else if ($urandom_range(1) == 0) begin
               pend[i]   = 1'b1;
               t_we[i]   = 1'($urandom_range(1));
               t_addr[i] = AW'($urandom_range(7));
               t_wd[i]   = $urandom;
            end
         end
         t_valid = pend;
         t_hold  = ($urandom_range(7) == 0);
         rst     = ($urandom_range(199) == 0);
         tick();
      end
      t_valid = '0;
      t_hold  = 1'b0;
      rst     = 1'b0;
      tick();
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/register_port_arbiter.md
# register_port_arbiter

Round-robin arbiter that shares the single read/write port of the CPU's 32 x 32-bit register file among N_REQ requesters (core writeback, debug module, test loader, etc.). Each requester issues one read or write per valid/ready handshake. The arbiter registers the winning transaction onto the register-file port and returns a one-cycle response pulse to the owner two cycles after acceptance. Sustained throughput is one transaction per cycle.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- ADDR_W, default 5: register address width.
- clk  in  1: clock; all state updates on posedge.
- rst  in  1: reset rst, synchronous, active-high; clock clk.
- hold  in  1: when 1, no new grant is issued; in-flight transactions still complete.
- req_valid  in  N_REQ: request present, bit i per requester.
- req_ready  out  N_REQ: grant, one-hot or zero; combinational from req_valid, hold and the priority pointer.
- req_we  in  N_REQ: 1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_W: requester i in bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*32: requester i in bits [i*32 +: 32].
- rf_addr  out  ADDR_W: register-file address, registered.
- rf_we  out  1: register-file write enable, registered.
- rf_wd  out  32: register-file write data, registered.
- rf_rd  in  32: register-file asynchronous read data for rf_addr.
- rsp_valid  out  N_REQ: one-cycle response pulse to the owner, registered.
- rsp_rdata  out  32: read data for the pulsing requester, registered.

## Operation
- Priority pointer prio ranges 0..N_REQ-1. Search order is prio, prio+1, ..., wrapping modulo N_REQ. The first i with req_valid[i]=1 wins.
- req_ready[winner]=1 only when hold=0 and at least one request is valid. All other bits are 0. req_ready never depends on req_we, req_addr or req_wdata.
- On acceptance (req_valid[i] & req_ready[i]), prio becomes (i+1) mod N_REQ. With no acceptance, prio is unchanged.
- Stage 1 registers: s1_valid, s1_id, rf_addr, rf_we, rf_wd.
  - Loaded from the winner on acceptance.
  - Otherwise: s1_valid=0, rf_we=0; rf_addr and rf_wd hold their values.
- Stage 2 registers: rsp_valid and rsp_rdata.
  - If s1_valid=1: rsp_valid is one-hot at bit s1_id and rsp_rdata = rf_rd.
  - Otherwise: rsp_valid=0 and rsp_rdata holds its value.
- Write response: rsp_rdata carries the old register value, sampled before the write edge.
- Address 0 is passed through unchanged; x0 semantics belong to the register file.
- Requesters must hold req_valid and payload stable until accepted. A dropped request before acceptance is legal and has no effect.
- Response storage is not limited by backpressure, so no internal buffering beyond stage 1 and stage 2.

## Timing
- Reset values: prio=0, s1_valid=0, s1_id=0, rf_we=0, rf_addr=0, rf_wd=0, rsp_valid=0, rsp_rdata=0.
- req_ready is 0 whenever rst=1.
- Latency:
  - Acceptance in cycle T.
  - rf_addr, rf_we and rf_wd are valid in cycle T+1; the write lands at the end of T+1.
  - rsp_valid pulses in cycle T+2.
- Back-to-back: a new acceptance is allowed every cycle, including by the same requester when it is the only one valid.
- Read after write, same address, consecutive acceptances: the read in T+1 returns the new value.
- hold rising at T: no acceptance at T. Transactions accepted at T-1 and T-2 still produce their responses. prio is frozen.
- rst mid-operation: in-flight stage 1 and stage 2 are discarded. No rsp_valid and no rf_we appear in the cycle after rst.
- Simultaneous events: all requesters valid gives strict rotation 0, 1, 2, 3, 0, ... from reset.

## Test plan
- Single read: after reset, requester 2 reads addr 5 holding 0xDEADBEEF.
  - req_ready=4'b0100 at T.
  - rf_addr=5, rf_we=0 at T+1.
  - rsp_valid=4'b0100 and rsp_rdata=0xDEADBEEF at T+2.
- Full contention: all 4 valid for 8 cycles → grants 0, 1, 2, 3, 0, 1, 2, 3, one per cycle, with responses following two cycles later in the same order.
- Write then read: requester 1 writes 0x12345678 to addr 7 (old value 0), then requester 1 reads addr 7 in the next cycle.
  - Write response rdata = 0.
  - Read response rdata = 0x12345678.
- Pointer retention: after grant to 1, only requesters 0 and 3 are valid → 3 wins before 0.
- hold: assert hold for 3 cycles with requests pending.
  - req_ready=0 throughout.
  - Prior two responses still arrive.
  - Granting resumes from the saved prio.
- Reset mid-flight: rst at T+1 after acceptance at T → rsp_valid=0 at T+2, rf_we=0, prio=0, and outputs at reset values.
